// File: rtl/boot_dispatcher.sv
// Boot dispatcher: queues host boot/enable commands and expands them into service messages.
// Optional BOOT_DISPATCHER_PERF_EN adds a saturating sent_count output.
module boot_dispatcher #(
  parameter int FIFO_DEPTH  = 4,
  parameter int THREAD_NUMB = 4,
  parameter int TILE_NUMB   = 4,
  parameter int ADDR_W      = 32,
  localparam int TID_W      = $clog2(THREAD_NUMB),
  localparam int HMSG_W     = 3 + ADDR_W + TID_W + THREAD_NUMB,
  localparam int SMSG_W     = 2 + HMSG_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   host_cmd_valid,
  output logic                   host_cmd_ready,
  input  logic [1:0]             host_cmd_op,
  input  logic [TILE_NUMB-1:0]   host_tile_mask,
  input  logic [THREAD_NUMB-1:0] host_thread_mask,
  input  logic [ADDR_W-1:0]      host_pc,
  input  logic [TID_W-1:0]       host_thread_id,
  input  logic                   network_available,
  output logic [SMSG_W-1:0]      message_out,
  output logic                   message_out_valid,
  output logic [TILE_NUMB-1:0]   destination_valid,
  output logic                   cmd_error
`ifdef BOOT_DISPATCHER_PERF_EN
  ,output logic [31:0]           sent_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [TID_W:0] LAST_THR = (TID_W+1)'(THREAD_NUMB);
  localparam logic [1:0]     SVC_HOST = 2'd1;

  typedef enum logic [1:0] {OP_ENABLE, OP_BOOT, OP_BOOT_ALL, OP_RSVD} op_e;
  typedef enum logic [1:0] {HM_NONE, HM_BOOT_COMMAND, HM_ENABLE_THREAD} hmsg_e;
  typedef enum logic {IDLE, SEND} state_e;

  typedef struct packed {
    hmsg_e                  message;
    logic                   hi_job_valid;
    logic [ADDR_W-1:0]      hi_job_pc;
    logic [TID_W-1:0]       hi_job_thread_id;
    logic [THREAD_NUMB-1:0] hi_thread_en;
  } host_message_t;

  typedef struct packed {
    logic [1:0]    message_type;
    host_message_t data;
  } service_message_t;

  typedef struct packed {
    op_e                    op;
    logic [TILE_NUMB-1:0]   tile;
    logic [THREAD_NUMB-1:0] tmask;
    logic [ADDR_W-1:0]      pc;
    logic [TID_W-1:0]       tid;
  } cmd_t;

  cmd_t             r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]   r_count;
  cmd_t             r_cmd;
  state_e           r_state, w_state_nxt;
  logic [TID_W:0]   r_thr_cnt, w_thr_cnt_nxt;
  cmd_t             w_push_cmd, w_head;
  logic             w_push, w_pop, w_load;
  service_message_t w_msg;

  assign host_cmd_ready = (r_count != FULL_CNT);
  assign w_push         = host_cmd_valid && host_cmd_ready;
  assign w_pop          = (r_state == IDLE) && (r_count != '0);
  assign w_head         = r_fifo[r_rd_ptr];
  assign w_push_cmd     = '{op: op_e'(host_cmd_op), tile: host_tile_mask,
                            tmask: host_thread_mask, pc: host_pc, tid: host_thread_id};

  // Storage needs no reset: an entry is only read once the count covers it.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_push_cmd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_thr_cnt <= '0;
      r_cmd     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_thr_cnt <= w_thr_cnt_nxt;
      if (w_load) r_cmd <= w_head;
    end
  end

  // Reserved ops are consumed in IDLE without ever reaching the command register.
  always_comb begin
    w_state_nxt   = r_state;
    w_thr_cnt_nxt = r_thr_cnt;
    w_load        = 1'b0;
    cmd_error     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pop) begin
          if (w_head.op == OP_RSVD) begin
            cmd_error = 1'b1;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = SEND;
          end
        end
      end
      SEND: begin
        if (network_available) begin
          if (r_cmd.op == OP_BOOT_ALL && r_thr_cnt != LAST_THR) begin
            w_thr_cnt_nxt = r_thr_cnt + (TID_W+1)'(1);
          end else begin
            w_thr_cnt_nxt = '0;
            w_state_nxt   = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_msg = '0;
    if (r_state == SEND) begin
      w_msg.message_type = SVC_HOST;
      case (r_cmd.op)
        OP_ENABLE: begin
          w_msg.data.message      = HM_ENABLE_THREAD;
          w_msg.data.hi_thread_en = r_cmd.tmask;
        end
        OP_BOOT: begin
          w_msg.data.message          = HM_BOOT_COMMAND;
          w_msg.data.hi_job_valid     = 1'b1;
          w_msg.data.hi_job_pc        = r_cmd.pc;
          w_msg.data.hi_job_thread_id = r_cmd.tid;
        end
        OP_BOOT_ALL: begin
          if (r_thr_cnt == LAST_THR) begin
            w_msg.data.message      = HM_ENABLE_THREAD;
            w_msg.data.hi_thread_en = r_cmd.tmask;
          end else begin
            w_msg.data.message          = HM_BOOT_COMMAND;
            w_msg.data.hi_job_valid     = 1'b1;
            w_msg.data.hi_job_pc        = r_cmd.pc;
            w_msg.data.hi_job_thread_id = r_thr_cnt[TID_W-1:0];
          end
        end
        default: w_msg = '0;
      endcase
    end
  end

  assign message_out       = w_msg;
  assign message_out_valid = (r_state == SEND) && network_available;
  assign destination_valid = (r_state == SEND) ? r_cmd.tile : '0;

`ifdef BOOT_DISPATCHER_PERF_EN
  logic [31:0] r_sent_count;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                    r_sent_count <= '0;
    else if (message_out_valid && r_sent_count != '1) r_sent_count <= r_sent_count + 32'd1;
  end
  assign sent_count = r_sent_count;
`endif

endmodule

// File: doc/boot_dispatcher.md
BOOT_DISPATCHER -- requirements
Module: boot_dispatcher

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command FIFO entries; power of two, at least 2.
REQ-002 Port clk, input, 1, single clock for all state.
REQ-003 Port reset, input, 1, asynchronous active-low reset.
REQ-004 Port host_cmd_valid, input, 1, host command present.
REQ-005 Port host_cmd_ready, output, 1, FIFO can accept a command.
REQ-006 Port host_cmd_op, input, 2, operation: 0 ENABLE, 1 BOOT, 2 BOOT_ALL, 3 reserved.
REQ-007 Port host_tile_mask, input, tile_mask_t, destination tiles.
REQ-008 Port host_thread_mask, input, THREAD_NUMB, thread-enable mask.
REQ-009 Port host_pc, input, address_t, job start PC.
REQ-010 Port host_thread_id, input, thread_id_t, target thread for BOOT.
REQ-011 Port network_available, input, 1, network accepts a service message this cycle.
REQ-012 Port message_out, output, service_message_t, outgoing message; data carries host_message_t.
REQ-013 Port message_out_valid, output, 1, message_out transferred this cycle.
REQ-014 Port destination_valid, output, tile_mask_t, destination mask for message_out.
REQ-015 Port cmd_error, output, 1, one-cycle pulse on dropped reserved op.

Function
REQ-016 Command push when host_cmd_valid && host_cmd_ready; host_cmd_ready = FIFO not full.
- All fields stored.
- Full FIFO: host_cmd_ready=0; command held by host, nothing lost.
REQ-017 FSM states IDLE, SEND.
- IDLE, FIFO non-empty: pop head into command register, enter SEND next cycle.
- Op 3: popped, cmd_error pulses one cycle, no message sent, FSM stays IDLE.
REQ-018 SEND: message_out_valid = network_available (combinational); message transfers that cycle.
- network_available low: message_out and destination_valid held stable.
REQ-019 ENABLE sends one message: message=ENABLE_THREAD, hi_thread_en=host_thread_mask.
REQ-020 BOOT sends one message: message=BOOT_COMMAND, hi_job_valid=1, hi_job_pc=host_pc, hi_job_thread_id=host_thread_id.
REQ-021 BOOT_ALL sends THREAD_NUMB+1 messages in order.
- BOOT_COMMAND for thread 0 up to thread THREAD_NUMB-1, all with pc=host_pc.
- Then ENABLE_THREAD with host_thread_mask.
- Internal thread counter advances only on transfer.
REQ-022 Unused host_message_t fields are zero.
- destination_valid = stored host_tile_mask whenever in SEND.
REQ-023 After the last message transfers, FSM returns to IDLE.
- Earliest next message: 2 cycles after that transfer (pop cycle, then SEND).
REQ-024 Latency: command pushed at cycle N into an empty FIFO, idle FSM.
- Popped at N+1.
- message_out_valid earliest at N+2 (network_available=1).
REQ-025 Push and pop in the same cycle are both legal; occupancy is unchanged.
REQ-026 Pointers wrap modulo FIFO_DEPTH; full/empty decided by an occupancy count of width log2(FIFO_DEPTH)+1.
REQ-027 Outside SEND, message_out_valid=0.
- cmd_error=0 except on the pop cycle of op 3.

Reset
REQ-028 reset low, asynchronous:
- FIFO empty; FSM IDLE; thread counter 0.
- message_out_valid=0, cmd_error=0.
- message_out=0, destination_valid=0.
- host_cmd_ready=1 once reset deasserts.
REQ-029 Reset mid-sequence (including mid BOOT_ALL):
- Abandons the in-flight command and all queued commands.
- No further messages sent from them.

Configuration
REQ-030 Macro BOOT_DISPATCHER_PERF_EN.
- Defined: extra output sent_count, 32 bits, counts transferred messages, saturates at all-ones, reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

Verification
REQ-031 ENABLE, tile mask 0x3, thread mask 0xF, network_available=1, pushed at N -> single valid at N+2: ENABLE_THREAD, hi_thread_en=0xF, destination_valid=0x3.
REQ-032 BOOT_ALL, pc 0x400, network_available held 1 -> THREAD_NUMB consecutive BOOT_COMMAND with thread ids 0..THREAD_NUMB-1, pc 0x400, then ENABLE_THREAD, then IDLE.
REQ-033 BOOT, network_available low 5 cycles in SEND -> no valid; message_out and destination stable; valid on first cycle available=1.
REQ-034 Push FIFO_DEPTH+1 commands, network_available=0 -> ready drops after 4 pops-free pushes (one in register); releasing network drains all in order, none lost.
REQ-035 Op 3, then BOOT -> one-cycle cmd_error, no message for op 3, BOOT message follows normally.
REQ-036 Reset low during 2nd message of BOOT_ALL, 2 commands queued -> valid drops at once; after release no messages until new push; sent_count=0 with BOOT_DISPATCHER_PERF_EN.
